// File: rtl/dice_roll_scheduler.sv
// dice_roll_scheduler: shares one die-roll engine between the local button path (A)
// and the I2C host (B). Each roll is granted, spins a wrapping down-counter, latches
// the counter as the result and pulses done for one cycle.
// Optional feature macro: ROLL_STATS_EN (saturating count of successful rolls on
// roll_count). Without it roll_count is tied to zero.
module dice_roll_scheduler #(
  parameter int unsigned SIDES_W = 7,
  parameter int unsigned SPIN_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_req,
  input  logic [SIDES_W-1:0] a_sides,
  input  logic               b_req,
  input  logic [SIDES_W-1:0] b_sides,
  input  logic [SPIN_W-1:0]  b_spin,
  output logic               a_gnt,
  output logic               b_gnt,
  output logic               done,
  output logic               err,
  output logic               owner,
  output logic [SIDES_W-1:0] result,
  output logic               result_valid,
  output logic               busy,
  output logic [7:0]         roll_count
);

  typedef enum logic [1:0] {StIdle, StSpin, StDone} state_e;

  state_e             state_q, state_d;
  logic               pend_q, pend_d;
  logic               last_q, last_d;    // owner of the previous grant, for round-robin
  logic               owner_q, owner_d;
  logic               err_q, err_d;
  logic [SIDES_W-1:0] sides_q, sides_d;
  logic [SPIN_W-1:0]  spin_q, spin_d;    // remaining SPIN cycles after this one (B only)
  logic [SIDES_W-1:0] ctr_q, ctr_d;
  logic [SIDES_W-1:0] result_q, result_d;
  logic               valid_q, valid_d;
  logic               grant_b;
  logic               pick_b;
  logic               spin_exit;
  logic [SIDES_W-1:0] sel_sides;
  logic               roll_ok;           // DONE cycle of a roll that produced a result

  // Next-state logic: arbitration in IDLE, counter spin, one-cycle DONE.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    err_d     = err_q;
    sides_d   = sides_q;
    spin_d    = spin_q;
    ctr_d     = ctr_q;
    result_d  = result_q;
    valid_d   = valid_q;
    grant_b   = 1'b0;
    pick_b    = 1'b0;
    spin_exit = 1'b0;
    sel_sides = a_sides;
    roll_ok   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (a_req || pend_q) begin
          // B wins when it is the only candidate, or on a tie when A went last.
          pick_b    = pend_q && (!a_req || !last_q);
          grant_b   = pick_b;
          sel_sides = pick_b ? b_sides : a_sides;
          owner_d   = pick_b;
          last_d    = pick_b;
          sides_d   = sel_sides;
          spin_d    = pick_b ? b_spin : '0;
          ctr_d     = sel_sides;
          if (sel_sides == '0) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            err_d   = 1'b0;
            state_d = StSpin;
          end
        end
      end
      StSpin: begin
        spin_exit = owner_q ? (spin_q == '0) : !a_req;
        ctr_d     = (ctr_q == SIDES_W'(1)) ? sides_q : ctr_q - 1'b1;
        if (spin_q != '0) begin
          spin_d = spin_q - 1'b1;
        end
        if (spin_exit) begin
          result_d = ctr_q;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (!err_q) begin
          valid_d = 1'b1;
          roll_ok = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // One-deep B request; a pulse coincident with B's grant re-arms it.
    if (b_req) begin
      pend_d = 1'b1;
    end else if (grant_b) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pend_q   <= 1'b0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      err_q    <= 1'b0;
      sides_q  <= '0;
      spin_q   <= '0;
      ctr_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
      sides_q  <= sides_d;
      spin_q   <= spin_d;
      ctr_q    <= ctr_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  // Outputs decoded from state.
  always_comb begin
    a_gnt        = (state_q == StSpin) && !owner_q;
    b_gnt        = (state_q == StSpin) && owner_q;
    done         = (state_q == StDone);
    err          = (state_q == StDone) && err_q;
    busy         = (state_q != StIdle);
    owner        = owner_q;
    result       = result_q;
    result_valid = valid_q;
  end

`ifdef ROLL_STATS_EN
  logic [7:0] count_q;

  // Saturating count of successful rolls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
    end else if (roll_ok && (count_q != 8'hFF)) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign roll_count = count_q;
`else
  logic unused_roll_ok;
  assign unused_roll_ok = roll_ok;
  assign roll_count     = 8'd0;
`endif

endmodule

// File: tb/tb_dice_roll_scheduler.sv
// Directed bench for dice_roll_scheduler; expected values are hand-computed.
module tb_dice_roll_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req;
  logic [6:0] a_sides;
  logic       b_req;
  logic [6:0] b_sides;
  logic [7:0] b_spin;
  logic       a_gnt, b_gnt, done, err, owner, result_valid, busy;
  logic [6:0] result;
  logic [7:0] roll_count;

  int errors = 0;
  int checks = 0;
  int n;

  dice_roll_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .a_req        (a_req),
    .a_sides      (a_sides),
    .b_req        (b_req),
    .b_sides      (b_sides),
    .b_spin       (b_spin),
    .a_gnt        (a_gnt),
    .b_gnt        (b_gnt),
    .done         (done),
    .err          (err),
    .owner        (owner),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .roll_count   (roll_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {a_gnt, b_gnt, done, err, owner, result_valid, busy}, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_count"}, roll_count, 0);
  endtask

  initial begin
    rst = 1'b1; a_req = 0; a_sides = 0; b_req = 0; b_sides = 0; b_spin = 0;
    #12;
    check_all_zero("reset");
    rst = 1'b0;

    // B only: sides 6, spin 3 -> ctr 6,5,4,3, result 3, b_gnt for 4 cycles.
    b_sides = 7'd6; b_spin = 8'd3; b_req = 1'b1;
    step();
    b_req = 1'b0;
    check("b_not_yet_gnt", b_gnt, 0);
    step();
    check("b_owner", owner, 1);
    n = 0;
    for (int i = 0; i < 20 && b_gnt; i++) begin
      n++;
      if (i == 0) b_sides = 7'd50;  // must be ignored mid-spin
      step();
    end
    check("b_gnt_cycles", n, 4);
    check("b_done", {done, err}, 2'b10);
    check("b_result", result, 3);
    step();
    check("b_done_1cycle", done, 0);
    check("b_valid", result_valid, 1);
    check("b_idle", busy, 0);

    // A only: sides 20, 24 SPIN cycles held, released on 25th -> result 16.
    a_sides = 7'd20; a_req = 1'b1;
    step();
    check("a_gnt_start", {a_gnt, b_gnt, owner}, 3'b100);
    a_sides = 7'd3;
    for (int i = 0; i < 24; i++) step();
    check("a_gnt_held", a_gnt, 1);
    a_req = 1'b0;
    step();
    check("a_gnt_drop", a_gnt, 0);
    check("a_done", done, 1);
    check("a_result", result, 16);
    step();

    // Reset clears result and result_valid; last returns to B.
    rst = 1'b1;
    #1;
    check_all_zero("reset2");
    rst = 1'b0;

    // Tie after reset: A first, then B wins the next tie (round-robin).
    a_sides = 7'd1; b_sides = 7'd4; b_spin = 8'd0;
    a_req = 1'b1; b_req = 1'b1;
    step();
    b_req = 1'b0;
    check("tie_a_first", {a_gnt, b_gnt}, 2'b10);
    step();
    a_req = 1'b0;
    step();
    check("tie_a_done", done, 1);
    check("tie_a_result_d1", result, 1);
    a_req = 1'b1;
    step();
    check("tie_no_grant_in_done", {a_gnt, b_gnt, busy}, 3'b000);
    step();
    check("tie_b_second", {a_gnt, b_gnt}, 2'b01);
    a_req = 1'b0;
    step();
    check("tie_b_done", {done, owner}, 2'b11);
    check("tie_b_result", result, 4);
    step();
    step();
    check("tie_no_extra_b", busy, 0);

    // sides==0 rejection: done&err, no b_gnt, result and result_valid unchanged.
    b_sides = 7'd0; b_req = 1'b1;
    step();
    b_req = 1'b0;
    step();
    check("err_pulse", {done, err, b_gnt}, 3'b110);
    check("err_result_kept", result, 4);
    step();
    check("err_after", {done, err, result_valid}, 3'b001);

    // Two b_req pulses during A's spin -> exactly one B roll.
    a_sides = 7'd5; a_req = 1'b1; b_sides = 7'd7; b_spin = 8'd1;
    step();
    b_req = 1'b1; step();
    b_req = 1'b0; step();
    b_req = 1'b1; step();
    b_req = 1'b0; a_req = 1'b0; step();
    check("dbl_a_result", {done, 1'b0, result}, {1'b1, 1'b0, 7'd2});
    step();
    step();
    check("dbl_b_gnt", b_gnt, 1);
    step();
    step();
    check("dbl_b_result", {done, 1'b0, result}, {1'b1, 1'b0, 7'd6});
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (busy) n++;
    end
    check("dbl_one_b_roll", n, 0);

    // Async reset in the middle of a B spin.
    b_sides = 7'd9; b_spin = 8'd10; b_req = 1'b1;
    step();
    b_req = 1'b0;
    step();
    check("mid_b_gnt", b_gnt, 1);
    step();
    #2 rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    rst = 1'b0;
    b_sides = 7'd3; b_spin = 8'd2; b_req = 1'b1;
    step();
    b_req = 1'b0;
    step();
    check("post_rst_gnt", b_gnt, 1);
    step(); step(); step();
    check("post_rst_result", {done, 1'b0, result}, {1'b1, 1'b0, 7'd1});
    step();
    check("post_rst_valid", result_valid, 1);

`ifdef ROLL_STATS_EN
    check("stats_one", roll_count, 1);
    b_sides = 7'd1; b_spin = 8'd0;
    for (int i = 0; i < 300; i++) begin
      b_req = 1'b1; step();
      b_req = 1'b0; step(); step(); step();
    end
    check("stats_sat", roll_count, 255);
`else
    check("stats_off", roll_count, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
